// File: rtl/repeater_tb_pkg.sv
// Shared state codes, LFSR polynomials and step helpers for the repeater traffic generator.
package repeater_tb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [63:0] DEFAULT_POLY = 64'hD800_0000_0000_0000;
  localparam logic [7:0]  THR_POLY     = 8'hB8;

  function automatic logic [63:0] lfsr_step64(input logic [63:0] x, input logic [63:0] poly);
    return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
  endfunction

  function automatic logic [7:0] lfsr_step8(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ THR_POLY) : (x >> 1);
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// Registered Galois LFSR; load returns it to SEED, adv takes one step.
module stream_lfsr
  import repeater_tb_pkg::*;
#(
  parameter int           W    = 64,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY),
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] q
);

  logic [W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
    end
  end

  assign q = lfsr;

endmodule

// File: rtl/repeater_traffic_gen.sv
// Pseudo-random val/rdy stimulus source: throttled LFSR word stream into the repeater
// input, throttled backpressure on the repeater output.
module repeater_traffic_gen
  import repeater_tb_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] SEED     = DATA_W'(64'hACE1_0000_0000_0001),
  parameter logic [DATA_W-1:0] POLY     = DATA_W'(DEFAULT_POLY),
  parameter logic [7:0]        THR_SEED = 8'h5A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       num_words,
  input  logic [7:0]        val_density,
  input  logic [7:0]        rdy_density,
  output logic              val1,
  output logic [DATA_W-1:0] dat1,
  input  logic              rdy1,
  output logic              rdy2,
  output logic [31:0]       sent_count,
  output logic              busy,
  output logic              done
);

  logic [1:0]  state;
  logic [31:0] num_words_q;
  logic [31:0] sent_count_q;
  logic        val1_q;
  logic        rdy2_q;
  logic [7:0]  t_val;
  logic [7:0]  t_rdy;
  logic        go1;
  logic        accept_start;
  logic        thr_adv;
  logic        val_hit;
  logic        rdy_hit;

  assign go1          = val1_q & rdy1;
  assign accept_start = start & ((state == IDLE) | (state == DONE));
  assign thr_adv      = (state == RUN) | (state == DONE);
  assign val_hit      = (t_val <= val_density);
  assign rdy_hit      = (t_rdy <= rdy_density);

  stream_lfsr #(.W(DATA_W), .POLY(POLY), .SEED(SEED)) u_data_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_start),
    .adv   (go1),
    .q     (dat1)
  );

  // Throttles free-run through RUN and DONE and are never reloaded by start.
  stream_lfsr #(.W(8), .POLY(THR_POLY), .SEED(THR_SEED)) u_val_thr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .adv   (thr_adv),
    .q     (t_val)
  );

  stream_lfsr #(.W(8), .POLY(THR_POLY), .SEED(THR_SEED)) u_rdy_thr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .adv   (thr_adv),
    .q     (t_rdy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      val1_q       <= 1'b0;
      sent_count_q <= '0;
      num_words_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_words_q  <= num_words;
            sent_count_q <= '0;
            state        <= (num_words == 32'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Once raised, val1 holds until the handshake completes.
          if (go1) begin
            sent_count_q <= sent_count_q + 32'd1;
            if (sent_count_q + 32'd1 == num_words_q) begin
              state  <= DONE;
              val1_q <= 1'b0;
            end else begin
              val1_q <= val_hit;
            end
          end else if (!val1_q) begin
            val1_q <= val_hit;
          end
        end
        default: begin
          state  <= IDLE;
          val1_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy2_q <= 1'b0;
    end else begin
      rdy2_q <= thr_adv & rdy_hit;
    end
  end

  assign val1       = val1_q;
  assign rdy2       = rdy2_q;
  assign sent_count = sent_count_q;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_repeater_traffic_gen.sv
// Directed + randomized bench for repeater_traffic_gen with a word-sequence reference model.
module tb_repeater_traffic_gen;

  localparam logic [63:0] SEED_C = 64'hACE1_0000_0000_0001;
  localparam logic [63:0] POLY_C = 64'hD800_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] num_words;
  logic [7:0]  val_density;
  logic [7:0]  rdy_density;
  logic        val1;
  logic [63:0] dat1;
  logic        rdy1;
  logic        rdy2;
  logic [31:0] sent_count;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  repeater_traffic_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .val_density (val_density),
    .rdy_density (rdy_density),
    .val1        (val1),
    .dat1        (dat1),
    .rdy1        (rdy1),
    .rdy2        (rdy2),
    .sent_count  (sent_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word k of a run is the k-fold LFSR step of the seed.
  function automatic logic [63:0] next_word(input logic [63:0] x);
    logic [63:0] sh;
    sh = x >> 1;
    if (x[0]) return sh ^ POLY_C;
    return sh;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int nw, input logic [7:0] vd, input logic [7:0] rd);
    @(negedge clk);
    num_words   = nw;
    val_density = vd;
    rdy_density = rd;
    start       = 1'b1;
  endtask

  // mode 0: rdy1 always 1; 1: random; 2: rdy1 low for loop cycles 4..13.
  task automatic stream(input int nw, input int mode, input int abort_at, input int inject_at,
                        output int val_cycles, output int span, output int rdy2_hi,
                        output int cycles);
    logic [63:0] exp_word;
    logic [63:0] prev_dat;
    int          idx;
    int          first_v;
    int          last_v;
    int          budget;
    bit          prev_val;
    bit          prev_go;
    bit          go;
    bit          fin;
    exp_word = SEED_C;
    prev_dat = '0;
    idx = 0; first_v = -1; last_v = -1;
    prev_val = 0; prev_go = 0; fin = 0;
    val_cycles = 0; rdy2_hi = 0; cycles = 0;
    budget = nw * 40 + 100;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      cycles = cyc + 1;
      if (done) begin
        fin = 1;
        break;
      end
      chk("busy_in_run", busy, 1'b1);
      chk("sent_count_track", sent_count, idx);
      if (prev_val && !prev_go) begin
        chk("val1_hold", val1, 1'b1);
        chk("dat1_hold", dat1, prev_dat);
      end
      start     = (cyc == inject_at);
      num_words = (cyc == inject_at) ? 32'd3 : nw;
      case (mode)
        0:       rdy1 = 1'b1;
        1:       rdy1 = $urandom_range(0, 1);
        default: rdy1 = !(cyc >= 4 && cyc <= 13);
      endcase
      go = val1 && rdy1;
      if (val1) begin
        val_cycles++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (rdy2) rdy2_hi++;
      if (go) begin
        chk("dat1_word", dat1, exp_word);
        exp_word = next_word(exp_word);
        idx++;
      end
      prev_val = val1;
      prev_go  = go;
      prev_dat = dat1;
      if (abort_at >= 0 && idx == abort_at && go) begin
        span = last_v - first_v + 1;
        return;
      end
    end
    start = 1'b0;
    span  = last_v - first_v + 1;
    chk("stream_finished", fin, 1'b1);
    if (fin) begin
      chk("final_sent_count", sent_count, nw);
      chk("model_word_count", idx, nw);
      chk("val1_low_in_done", val1, 1'b0);
      chk("busy_low_in_done", busy, 1'b0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_val1"}, val1, 1'b0);
    chk({tag, "_dat1"}, dat1, SEED_C);
    chk({tag, "_rdy2"}, rdy2, 1'b0);
    chk({tag, "_sent"}, sent_count, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int vc, sp, rh, cy, vd_r, nw_r;
    rst_n = 1'b0; start = 1'b0; num_words = '0;
    val_density = '0; rdy_density = '0; rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Four words back to back at full density.
    do_start(4, 8'hFF, 8'hFF);
    stream(4, 0, -1, -1, vc, sp, rh, cy);
    chk("t1_val_cycles", vc, 4);
    chk("t1_contiguous", sp, 4);
    chk("t1_done", done, 1'b1);
    chk("t1_rdy2_in_done", rdy2, 1'b1);

    // Ten-cycle stall mid-stream; rdy2 throttled fully off.
    do_start(20, 8'hFF, 8'h00);
    stream(20, 2, -1, -1, vc, sp, rh, cy);
    chk("t2_val_cycles", vc, 30);
    chk("t2_no_gap", sp, 30);
    chk("t2_rdy2_never", rh, 0);

    // Start during RUN must not reload num_words or restart.
    do_start(8, 8'hFF, 8'h80);
    stream(8, 1, -1, 3, vc, sp, rh, cy);
    repeat (4) begin
      @(negedge clk);
      chk("t4_quiet_after_done", val1, 1'b0);
    end

    // Reset after three of eight words.
    do_start(8, 8'hFF, 8'hFF);
    stream(8, 0, 3, -1, vc, sp, rh, cy);
    start = 1'b0;
    @(negedge clk);
    chk("t5_three_sent", sent_count, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("t5_abort");
    vd_r = $urandom_range(32, 255);
    do_start(5, vd_r[7:0], 8'hFF);
    stream(5, 1, -1, -1, vc, sp, rh, cy);

    // Zero-length run from IDLE.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t3_idle_done", done, 1'b0);
    do_start(0, 8'hFF, 8'hFF);
    @(negedge clk);
    start = 1'b0;
    chk("t3_done", done, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_sent", sent_count, 32'd0);
    vc = 0;
    repeat (6) begin
      @(negedge clk);
      if (val1) vc++;
    end
    chk("t3_val_never", vc, 0);

    // Long throttled runs with random backpressure, repeated from DONE.
    for (int r = 0; r < 2; r++) begin
      do_start(2000, 8'h40, 8'h40);
      stream(2000, 1, -1, -1, vc, sp, rh, cy);
      chk("t6_rdy2_throttled", (rh > 0) && (rh * 2 < cy), 1'b1);
    end

    // Random-length run at a random density.
    nw_r = $urandom_range(1, 60);
    vd_r = $urandom_range(16, 255);
    do_start(nw_r, vd_r[7:0], 8'hC0);
    stream(nw_r, 1, -1, -1, vc, sp, rh, cy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
